mfp_ahb_avalon_bridge: RTL and testbench
========================================

Name: mfp_ahb_avalon_bridge

Overview:
- Single-transfer AHB-Lite slave to Avalon-MM master bridge. Connects the mfp_system memory bus to the lpddr2_mm controller port (avm_* signals).
- Converts each AHB read or write into exactly one Avalon transaction with burstcount 1.
- Inserts AHB wait states until the Avalon side completes.
- A watchdog counter issues an AHB ERROR response if the memory stops responding.
- Runs in one clock domain. When the memory clock differs from the system clock, clock-domain crossing is handled outside this block.

Parameters:
- ADDR_WIDTH, 27, Avalon word-address width; avm_address = HADDR[ADDR_WIDTH+1:2].
- TIMEOUT_CYCLES, 1024, cycles a transaction may spend waiting before the ERROR response is issued; minimum 4.

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; NONSEQ=2'b10, SEQ=2'b11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half-word, 2 = word.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data.
- HREADY  out  1  transfer done / slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- avm_address  out  ADDR_WIDTH  word address.
- avm_byteenable  out  4  byte lanes.
- avm_burstcount  out  3  constant 3'd1.
- avm_beginbursttransfer  out  1  pulse on the first request cycle.
- avm_begintransfer  out  1  pulse on the first request cycle.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data strobe.
- avm_waitrequest  in  1  request stall.

Behaviour:
- Reset (asynchronous, any state):
  - State = IDLE.
  - HREADY = 1, HRESP = 0, HRDATA = 0.
  - avm_read = avm_write = 0, avm_begin* = 0, avm_address = 0, avm_byteenable = 0, avm_writedata = 0.
  - Watchdog counter = 0.
  - Reset mid-transaction drops the Avalon request immediately. There is no retry.
- All outputs are registered except avm_burstcount, which is a constant.
- States: IDLE, WR_DATA, WR_REQ, RD_REQ, RD_WAIT, ERR1, ERR2.
- IDLE:
  - HREADY = 1, HRESP = 0.
  - Accept a transfer when HSEL & HTRANS[1] & HREADY.
  - On accept, latch the address and compute byteenable from HSIZE/HADDR[1:0]:
    - byte: 4'b0001 << HADDR[1:0].
    - half-word: 4'b0011 << {HADDR[1],1'b0}.
    - word: 4'b1111.
    - HSIZE > 2: treated as word.
  - Next state on accept: WR_DATA if HWRITE, else RD_REQ. HREADY goes 0 from the next cycle.
  - IDLE/BUSY HTRANS or HSEL = 0: no action, stays ready with OKAY.
- WR_DATA (1 cycle):
  - Latch HWDATA into avm_writedata.
  - Assert avm_write and the avm_begin* pulses.
  - Next state: WR_REQ.
- WR_REQ:
  - Hold avm_write and all request signals stable while avm_waitrequest = 1.
  - On avm_waitrequest = 0: drop avm_write, go to IDLE (HREADY = 1 the next cycle).
  - Minimum write latency: 2 wait states.
- RD_REQ:
  - First cycle: avm_read = 1 plus the avm_begin* pulses.
  - Hold the request while waitrequest = 1.
  - On acceptance: drop avm_read, go to RD_WAIT.
  - If avm_readdatavalid is also high in the acceptance cycle, capture the data and go straight to IDLE.
- RD_WAIT:
  - On avm_readdatavalid: HRDATA <= avm_readdata, go to IDLE.
  - HREADY = 1 and HRDATA are valid in the same cycle.
- avm_readdatavalid while in IDLE or in any write state: ignored; HRDATA is unchanged.
- Watchdog:
  - Cleared on entry to WR_DATA or RD_REQ; increments each cycle outside IDLE and the ERR states.
  - When it reaches TIMEOUT_CYCLES-1: deassert avm_read/avm_write and go to ERR1.
- AHB ERROR response:
  - ERR1: HREADY = 0, HRESP = 1 for one cycle.
  - ERR2: HREADY = 1, HRESP = 1 for one cycle.
  - Then IDLE.
- Pipelining: one transfer outstanding at a time. A new address phase is taken only in the cycle HREADY = 1 (IDLE), including back-to-back transfers.

Test Plan:
- Reset pulse mid-RD_REQ with avm_waitrequest = 1 → avm_read = 0 in the same cycle as rst; HREADY = 1 and HRDATA = 0 after release.
- Word write to HADDR 0x0000_0010, HWDATA 0xDEADBEEF, waitrequest = 0 → avm_address = 4, byteenable = 4'hF, writedata 0xDEADBEEF, avm_write high for exactly 1 cycle; HREADY low for 2 cycles.
- Byte write to HADDR 0x0000_0003, then half-word write to 0x0000_0002 → byteenable 4'b1000, then 4'b1100.
- Word read at 0x0000_0100, waitrequest held 3 cycles, readdatavalid 2 cycles after acceptance, data 0x12345678 → avm_read high 4 cycles with stable address 0x40; HRDATA = 0x12345678 with HREADY = 1.
- Back-to-back read then write, HTRANS NONSEQ each time → both Avalon transactions occur in order, one outstanding at a time, no lost or duplicated request.
- TIMEOUT_CYCLES = 8, waitrequest stuck at 1 on a read → avm_read drops after 8 cycles; HRESP = 1 for 2 cycles with HREADY 0 then 1; a later stray readdatavalid leaves HRDATA unchanged.

Source files
------------

// File: rtl/mfp_ahb_avalon_bridge.sv
// AHB-Lite single-transfer slave to Avalon-MM master bridge with watchdog.
// Ports: AHB slave (HSEL..HRESP), Avalon master (avm_*), clk, async rst.
module mfp_ahb_avalon_bridge #(
  parameter int ADDR_WIDTH     = 27,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic [3:0]            avm_byteenable,
  output logic [2:0]            avm_burstcount,
  output logic                  avm_beginbursttransfer,
  output logic                  avm_begintransfer,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DATA, S_WR_REQ, S_RD_REQ, S_RD_WAIT, S_ERR1, S_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic                  hready_q, hready_d;
  logic                  hresp_q, hresp_d;
  logic [31:0]           hrdata_q, hrdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  begin_q, begin_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [3:0]            be_calc;
  logic                  accept;
  logic                  expired;
  logic                  unused_ok;

  assign unused_ok = ^{HADDR[31:ADDR_WIDTH+2], HADDR[1:0], HTRANS[0]};

  always_comb begin
    be_calc = 4'b1111;
    unique case (HSIZE)
      3'd0:    be_calc = 4'b0001 << HADDR[1:0];
      3'd1:    be_calc = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be_calc = 4'b1111;
    endcase
  end

  assign accept  = HSEL & HTRANS[1] & hready_q;
  assign expired = (wdog_q == WD_MAX);

  always_comb begin
    state_d  = state_q;
    hready_d = hready_q;
    hresp_d  = hresp_q;
    hrdata_d = hrdata_q;
    addr_d   = addr_q;
    be_d     = be_q;
    read_d   = read_q;
    write_d  = write_q;
    begin_d  = 1'b0;
    wdata_d  = wdata_q;
    wdog_d   = wdog_q;
    unique case (state_q)
      S_IDLE: begin
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        if (accept) begin
          addr_d   = HADDR[ADDR_WIDTH+1:2];
          be_d     = be_calc;
          wdog_d   = '0;
          hready_d = 1'b0;
          if (HWRITE) begin
            state_d = S_WR_DATA;
          end else begin
            // read request is visible in the first RD_REQ cycle
            state_d = S_RD_REQ;
            read_d  = 1'b1;
            begin_d = 1'b1;
          end
        end
      end
      S_WR_DATA: begin
        wdata_d = HWDATA;
        write_d = 1'b1;
        begin_d = 1'b1;
        wdog_d  = wdog_q + 1'b1;
        state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        wdog_d = wdog_q + 1'b1;
        // timeout wins over a same-cycle completion
        if (expired) begin
          write_d = 1'b0;
          hresp_d = 1'b1;
          state_d = S_ERR1;
        end else if (!avm_waitrequest) begin
          write_d  = 1'b0;
          hready_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_RD_REQ: begin
        wdog_d = wdog_q + 1'b1;
        if (expired) begin
          read_d  = 1'b0;
          hresp_d = 1'b1;
          state_d = S_ERR1;
        end else if (!avm_waitrequest) begin
          read_d = 1'b0;
          if (avm_readdatavalid) begin
            hrdata_d = avm_readdata;
            hready_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (expired) begin
          hresp_d = 1'b1;
          state_d = S_ERR1;
        end else if (avm_readdatavalid) begin
          hrdata_d = avm_readdata;
          hready_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_ERR1: begin
        hready_d = 1'b1;
        hresp_d  = 1'b1;
        state_d  = S_ERR2;
      end
      S_ERR2: begin
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        read_d   = 1'b0;
        write_d  = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      begin_q  <= 1'b0;
      wdata_q  <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      hrdata_q <= hrdata_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      read_q   <= read_d;
      write_q  <= write_d;
      begin_q  <= begin_d;
      wdata_q  <= wdata_d;
      wdog_q   <= wdog_d;
    end
  end

  assign HRDATA                 = hrdata_q;
  assign HREADY                 = hready_q;
  assign HRESP                  = hresp_q;
  assign avm_address            = addr_q;
  assign avm_byteenable         = be_q;
  assign avm_burstcount         = 3'd1;
  assign avm_beginbursttransfer = begin_q;
  assign avm_begintransfer      = begin_q;
  assign avm_read               = read_q;
  assign avm_write              = write_q;
  assign avm_writedata          = wdata_q;

endmodule

// File: tb/tb_mfp_ahb_avalon_bridge.sv
// Randomized self-checking bench for mfp_ahb_avalon_bridge.
// Transaction-level model predicts latencies, request counts and data.
module tb_mfp_ahb_avalon_bridge;

  localparam int AW = 27;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = '0;
  logic [1:0]    HTRANS = 2'b00;
  logic          HWRITE = 1'b0;
  logic [2:0]    HSIZE = 3'd0;
  logic [31:0]   HWDATA = '0;
  logic [31:0]   HRDATA;
  logic          HREADY;
  logic          HRESP;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic [2:0]    avm_burstcount;
  logic          avm_beginbursttransfer;
  logic          avm_begintransfer;
  logic          avm_read;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic          avm_waitrequest = 1'b0;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   model_hrdata = '0;

  mfp_ahb_avalon_bridge #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .HSEL(HSEL),
    .HADDR(HADDR),
    .HTRANS(HTRANS),
    .HWRITE(HWRITE),
    .HSIZE(HSIZE),
    .HWDATA(HWDATA),
    .HRDATA(HRDATA),
    .HREADY(HREADY),
    .HRESP(HRESP),
    .avm_address(avm_address),
    .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount),
    .avm_beginbursttransfer(avm_beginbursttransfer),
    .avm_begintransfer(avm_begintransfer),
    .avm_read(avm_read),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One AHB transfer. w = waitrequest-high cycles before acceptance,
  // d = cycles from acceptance to readdatavalid (0 = same cycle).
  task automatic xfer(input bit wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      input int w, input int d, input logic [31:0] rdata);
    int a, c, exp_req, exp_low;
    bit to;
    logic [3:0] be;
    logic [AW-1:0] ea;
    int req_cnt, beg_cnt, bb_cnt, low, wrong, acc_k;
    bit done;
    logic resp_s;
    logic [31:0] rdata_s;
    if (!wr) begin
      a = w + 1;
      c = a + d;
      to = (c >= T);
      exp_req = to ? ((a < T) ? a : T) : a;
      exp_low = to ? T + 1 : c;
    end else begin
      a = w + 2;
      to = (a >= T);
      exp_req = to ? T - 1 : w + 1;
      exp_low = to ? T + 1 : w + 2;
    end
    case (size)
      3'd0:    be = 4'b0001 << addr[1:0];
      3'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    ea = addr[AW+1:2];
    req_cnt = 0; beg_cnt = 0; bb_cnt = 0; low = 0; wrong = 0;
    acc_k = -1; done = 0; resp_s = 1'b0; rdata_s = '0;
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HADDR = addr;
    HWRITE = wr;
    HSIZE = size;
    HWDATA = $urandom;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      step();
      if (k == 1) begin
        HSEL = $urandom_range(0, 1);
        HTRANS = 2'b00;
        HADDR = $urandom;
        HWRITE = $urandom_range(0, 1);
        HWDATA = wdata;
      end
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      if (HREADY) begin
        done = 1;
        resp_s = HRESP;
        rdata_s = HRDATA;
      end else begin
        low++;
        if (avm_begintransfer) beg_cnt++;
        if (avm_beginbursttransfer) bb_cnt++;
        if (wr ? avm_read : avm_write) wrong++;
        if (wr ? avm_write : avm_read) begin
          chk("addr", 32'(avm_address), 32'(ea));
          chk("byteen", 32'(avm_byteenable), 32'(be));
          if (wr) chk("wdata", avm_writedata, wdata);
          req_cnt++;
          avm_waitrequest = (req_cnt <= w);
          if (req_cnt == w + 1) acc_k = k;
        end else begin
          avm_waitrequest = $urandom_range(0, 1);
        end
        if (!wr && acc_k >= 0 && k == acc_k + d) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = rdata;
        end
      end
    end
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("wait_states", low, exp_low);
    chk("req_cycles", req_cnt, exp_req);
    chk("begin_pulses", beg_cnt, 1);
    chk("beginburst_pulses", bb_cnt, 1);
    chk("wrong_dir", wrong, 0);
    chk("hresp", 32'(resp_s), 32'(to));
    if (!wr && !to) model_hrdata = rdata;
    chk("hrdata", rdata_s, model_hrdata);
    if (to) begin
      step();
      chk("err_end_hready", 32'(HREADY), 32'd1);
      chk("err_end_hresp", 32'(HRESP), 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] ad;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_be", 32'(avm_byteenable), 32'd0);
    chk("burstcount", 32'(avm_burstcount), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();

    xfer(1, 32'h0000_0010, 3'd2, 32'hDEADBEEF, 0, 0, 0);
    xfer(1, 32'h0000_0003, 3'd0, 32'h1122_3344, 0, 0, 0);
    xfer(1, 32'h0000_0002, 3'd1, 32'h5566_7788, 1, 0, 0);
    xfer(0, 32'h0000_0100, 3'd2, 0, 3, 2, 32'h1234_5678);
    xfer(0, 32'h0000_0204, 3'd2, 0, 0, 0, 32'hA5A5_0001);
    xfer(1, 32'h0000_0208, 3'd2, 32'h0BAD_F00D, 2, 0, 0);
    xfer(0, 32'h0000_0300, 3'd2, 0, 20, 0, 32'hFFFF_0000);

    // stray readdatavalid in IDLE must not touch HRDATA
    HSEL = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hCAFE_0000;
    step();
    avm_readdatavalid = 1'b0;
    step();
    chk("stray_rdv", HRDATA, model_hrdata);

    for (int i = 0; i < 60; i++) begin
      ad = $urandom;
      ad[31:AW+2] = '0;
      xfer($urandom_range(0, 1), ad, 3'($urandom_range(0, 3)),
           $urandom, $urandom_range(0, 7), $urandom_range(0, 5),
           $urandom);
      if ($urandom_range(0, 3) == 0) begin
        HSEL = 1'b0;
        HTRANS = 2'b00;
        repeat ($urandom_range(1, 3)) step();
      end
    end

    // reset in the middle of a stalled read
    xfer(0, 32'h0000_0040, 3'd2, 0, 0, 1, 32'h0F0F_F0F0);
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HADDR = 32'h0000_0100;
    HWRITE = 1'b0;
    HSIZE = 3'd2;
    step();
    HSEL = 1'b0;
    HTRANS = 2'b00;
    avm_waitrequest = 1'b1;
    chk("mid_read_req", 32'(avm_read), 32'd1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_drops_read", 32'(avm_read), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    avm_waitrequest = 1'b0;
    model_hrdata = '0;
    step();
    chk("post_rst_hready", 32'(HREADY), 32'd1);
    chk("post_rst_hrdata", HRDATA, 32'd0);
    chk("post_rst_hresp", 32'(HRESP), 32'd0);
    chk("post_rst_read", 32'(avm_read), 32'd0);
    xfer(1, 32'h0000_0020, 3'd2, 32'h7777_8888, 0, 0, 0);
    xfer(0, 32'h0000_0024, 3'd2, 0, 1, 1, 32'h9999_AAAA);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
